// File: rtl/dma_device_port.sv
// dma_device_port: device-side DMA endpoint with a local 2^FIFO_DEPTH-word buffer.
// Define DMA_DEV_TIMEOUT_EN to enable the XFER/WAIT_END watchdog.
module dma_device_port #(
    parameter int ADD_LEN        = 5,
    parameter int DATA_LEN       = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_rd_wr,
    input  logic [FIFO_DEPTH:0]   in_num_words,
    input  logic [ADD_LEN-1:0]    in_start_address,
    input  logic                  buf_we,
    input  logic [FIFO_DEPTH-1:0] buf_addr,
    input  logic [DATA_LEN-1:0]   buf_wdata,
    output logic [DATA_LEN-1:0]   buf_rdata,
    input  logic                  dma_ack,
    input  logic [DATA_LEN-1:0]   dev_in,
    input  logic                  dma_end_flag,
    output logic                  rqst,
    output logic                  rd_wr,
    output logic [FIFO_DEPTH:0]   num_words,
    output logic [ADD_LEN-1:0]    start_address,
    output logic                  dev_ack,
    output logic [DATA_LEN-1:0]   dev_out,
    output logic                  dev_ready,
    output logic                  busy,
    output logic                  error
);
    localparam int LW = FIFO_DEPTH + 1;
    localparam logic [LW-1:0] DEPTH_WORDS = LW'(1 << FIFO_DEPTH);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
`ifdef DMA_DEV_TIMEOUT_EN
    localparam bit WD_EN = 1'b1;
`else
    // Counter stays at zero and is constant-folded away.
    localparam bit WD_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, XFER, WAIT_END, DONE} state_t;

    state_t                state_q, state_d;
    logic [LW-1:0]         k_q, k_d, k_inc;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic                  rd_wr_q, rd_wr_d;
    logic [LW-1:0]         num_q, num_d;
    logic [ADD_LEN-1:0]    addr_q, addr_d;
    logic                  rqst_q, rqst_d;
    logic                  dev_ack_q, dev_ack_d;
    logic [DATA_LEN-1:0]   dev_out_q, dev_out_d;
    logic                  dev_ready_q, dev_ready_d;
    logic                  busy_q, busy_d;
    logic                  error_q, error_d;
    logic [DATA_LEN-1:0]   buf_rdata_q, buf_rdata_d;
    logic [DATA_LEN-1:0]   buf_mem_q [1<<FIFO_DEPTH];
    logic                  mem_we, fire, last;
    logic [FIFO_DEPTH-1:0] mem_idx;
    logic [DATA_LEN-1:0]   mem_wdata;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        rd_wr_d     = rd_wr_q;
        num_d       = num_q;
        addr_d      = addr_q;
        error_d     = error_q;
        dev_out_d   = dev_out_q;
        dev_ack_d   = 1'b0;
        wd_d        = '0;
        mem_we      = 1'b0;
        mem_idx     = buf_addr;
        mem_wdata   = buf_wdata;
        buf_rdata_d = buf_mem_q[buf_addr];
        k_inc       = k_q + 1'b1;
        fire        = dma_ack & (rd_wr_q | dev_ack_q);
        last        = fire & (k_inc == num_q);
        case (state_q)
            IDLE: begin
                mem_we = buf_we;
                if (start) begin
                    rd_wr_d = in_rd_wr;
                    addr_d  = in_start_address;
                    k_d     = '0;
                    error_d = 1'b0;
                    num_d   = in_num_words;
                    if (in_num_words > DEPTH_WORDS) begin
                        num_d   = DEPTH_WORDS;
                        error_d = 1'b1;
                    end
                    if (in_num_words == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = XFER;
                        if (!in_rd_wr) begin
                            dev_ack_d = 1'b1;
                            dev_out_d = buf_mem_q[{FIFO_DEPTH{1'b0}}];
                        end
                    end
                end
            end
            XFER: begin
                if (!rd_wr_q) dev_ack_d = dev_ack_q;
                // An end flag on the final accepted word is a clean finish.
                if (dma_end_flag && !last) begin
                    state_d   = DONE;
                    error_d   = 1'b1;
                    dev_ack_d = 1'b0;
                end else if (fire) begin
                    k_d = k_inc;
                    if (rd_wr_q) begin
                        mem_we    = 1'b1;
                        mem_idx   = k_q[FIFO_DEPTH-1:0];
                        mem_wdata = dev_in;
                        dev_ack_d = 1'b1;
                    end else begin
                        dev_ack_d = !last;
                        dev_out_d = buf_mem_q[k_inc[FIFO_DEPTH-1:0]];
                    end
                    if (last) state_d = dma_end_flag ? DONE : WAIT_END;
                end
            end
            WAIT_END: if (dma_end_flag) state_d = DONE;
            default:  state_d = IDLE;
        endcase
        if (WD_EN && (state_q == XFER || state_q == WAIT_END)) begin
            wd_d = dma_ack ? '0 : wd_q + 1'b1;
            if (wd_d == WD_LIMIT && state_d != DONE) begin
                state_d   = DONE;
                error_d   = 1'b1;
                dev_ack_d = 1'b0;
            end
        end
        rqst_d      = (state_d == XFER) || (state_d == WAIT_END);
        busy_d      = (state_d != IDLE);
        dev_ready_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            wd_q        <= '0;
            rd_wr_q     <= 1'b0;
            num_q       <= '0;
            addr_q      <= '0;
            rqst_q      <= 1'b0;
            dev_ack_q   <= 1'b0;
            dev_out_q   <= '0;
            dev_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
            buf_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            wd_q        <= wd_d;
            rd_wr_q     <= rd_wr_d;
            num_q       <= num_d;
            addr_q      <= addr_d;
            rqst_q      <= rqst_d;
            dev_ack_q   <= dev_ack_d;
            dev_out_q   <= dev_out_d;
            dev_ready_q <= dev_ready_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
            buf_rdata_q <= buf_rdata_d;
        end
    end

    // Buffer contents survive reset; only writes are blocked while it is held.
    always_ff @(posedge clk) begin
        if (reset && mem_we) buf_mem_q[mem_idx] <= mem_wdata;
    end

    assign buf_rdata     = buf_rdata_q;
    assign rqst          = rqst_q;
    assign rd_wr         = rd_wr_q;
    assign num_words     = num_q;
    assign start_address = addr_q;
    assign dev_ack       = dev_ack_q;
    assign dev_out       = dev_out_q;
    assign dev_ready     = dev_ready_q;
    assign busy          = busy_q;
    assign error         = error_q;
endmodule
